// File: rtl/readin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : readin_pkg
// Description : Shared types and constants for the readin FIFO-bank writer.
//               Writer state encoding, state_o field offsets, default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package readin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } wr_state_t;

    // Bit positions inside state_o
    localparam int c_st_wr_lsb    = 0;
    localparam int c_st_rd_active = 2;
    localparam int c_st_err       = 3;

    // Default build sizes
    localparam int c_n_fifo_def = 5;
    localparam int c_dw_def     = 16;
    localparam int c_depth_def  = 16;

endpackage
`default_nettype wire

// File: rtl/readin_fifo_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : readin_fifo_fsm_if
// Description : Input stream, bank status and pop/readout bundle of the
//               readin FIFO-bank writer. READIN_FLUSH_EN adds flush_i and
//               rd_last_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface readin_fifo_fsm_if #(
    parameter int N_FIFO = 5,
    parameter int DW     = 16
);
    logic [DW-1:0]     s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [N_FIFO-1:0] fifo_full_o;
    logic [N_FIFO-1:0] fifo_ready_read_i;
    logic [DW-1:0]     rd_data_o;
    logic              rd_valid_o;
    logic [3:0]        state_o;
`ifdef READIN_FLUSH_EN
    logic              flush_i;
    logic              rd_last_o;

    modport slave (
        input  s_data_i, s_valid_i, fifo_ready_read_i, flush_i,
        output s_ready_o, fifo_full_o, rd_data_o, rd_valid_o, state_o, rd_last_o
    );
    modport master (
        output s_data_i, s_valid_i, fifo_ready_read_i, flush_i,
        input  s_ready_o, fifo_full_o, rd_data_o, rd_valid_o, state_o, rd_last_o
    );
`else
    modport slave (
        input  s_data_i, s_valid_i, fifo_ready_read_i,
        output s_ready_o, fifo_full_o, rd_data_o, rd_valid_o, state_o
    );
    modport master (
        output s_data_i, s_valid_i, fifo_ready_read_i,
        input  s_ready_o, fifo_full_o, rd_data_o, rd_valid_o, state_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/readin_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : readin_bank_ram
// Description : Storage for all banks, addressed {bank, index}. One
//               synchronous write port, one registered read port that
//               holds its value when not read.
// Revision    : 1.0 - initial release
// ============================================================================
module readin_bank_ram #(
    parameter int DW    = 16,
    parameter int AW    = 7,
    parameter int WORDS = 80
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);
    logic [DW-1:0] r_mem [WORDS];
    logic [DW-1:0] r_rd_data;

    // Write port; contents are not reset, validity lives in the bank counters
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port; output register clears on reset and holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/readin_fifo_fsm.sv
`default_nettype none
// ============================================================================
// Module      : readin_fifo_fsm
// Description : Fills N_FIFO banks round-robin from a valid/ready stream,
//               flags full banks and serves one-hot pops from the readout
//               FSM. Optional READIN_FLUSH_EN adds early bank close (flush_i)
//               and a last-word marker (rd_last_o).
// Revision    : 1.0 - initial release
// ============================================================================
module readin_fifo_fsm
    import readin_pkg::*;
#(
    parameter int N_FIFO = c_n_fifo_def,
    parameter int DW     = c_dw_def,
    parameter int DEPTH  = c_depth_def
) (
    input  logic             clk,
    input  logic             reset,
    readin_fifo_fsm_if.slave bus
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_bw = $clog2(N_FIFO);
    localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);
    localparam logic [c_bw-1:0] c_last_bank = c_bw'(N_FIFO - 1);

    wr_state_t          r_wr_state, w_wr_state_nxt;
    logic [c_bw-1:0]    r_wr_sel, w_wr_sel_nxt, w_sel_inc;
    logic [c_cw-1:0]    r_wr_cnt, w_wr_cnt_nxt, w_cnt_inc;
    logic [N_FIFO-1:0]  r_full;
    logic [c_cw-1:0]    r_level  [N_FIFO];
    logic [c_cw-1:0]    r_rd_cnt [N_FIFO];
    logic               r_err, r_rd_valid;
    logic               w_accept, w_flush, w_close;
    logic [c_cw-1:0]    w_close_level;
    logic [N_FIFO-1:0]  w_req;
    logic               w_onehot, w_pop, w_bad, w_rd_last, w_rd_active;
    logic [c_bw-1:0]    w_rd_bank;
    logic [c_cw-1:0]    w_rd_idx;

    assign bus.s_ready_o = (r_wr_state != STALL);
    assign w_accept      = bus.s_valid_i & bus.s_ready_o;

`ifdef READIN_FLUSH_EN
    logic r_rd_last;
    assign w_flush       = bus.flush_i;
    assign bus.rd_last_o = r_rd_last;
`else
    assign w_flush = 1'b0;
`endif

    // Writer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= IDLE;
            r_wr_sel   <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
        end
    end

    // Writer next state: a bank closes on its DEPTH-th word or on flush in FILL;
    // the next bank is judged against the pre-pop full flag, so a bank being
    // drained this very cycle still costs one STALL cycle.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_sel_nxt   = r_wr_sel;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_close        = 1'b0;
        w_cnt_inc      = r_wr_cnt + c_cw'(1);
        w_close_level  = w_accept ? w_cnt_inc : r_wr_cnt;
        w_sel_inc      = (r_wr_sel == c_last_bank) ? '0 : r_wr_sel + c_bw'(1);
        case (r_wr_state)
            IDLE: begin
                if (w_accept) begin
                    w_wr_state_nxt = FILL;
                    w_wr_cnt_nxt   = c_cw'(1);
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_wr_cnt_nxt = w_cnt_inc;
                end
                if ((w_accept && (w_cnt_inc == c_depth_cnt)) || w_flush) begin
                    w_close        = 1'b1;
                    w_wr_cnt_nxt   = '0;
                    w_wr_sel_nxt   = w_sel_inc;
                    w_wr_state_nxt = r_full[w_sel_inc] ? STALL : IDLE;
                end
            end
            STALL: begin
                if (!r_full[r_wr_sel]) begin
                    w_wr_state_nxt = IDLE;
                end
            end
            default: w_wr_state_nxt = IDLE;
        endcase
    end

    // Pop request decode: valid only when one-hot and aimed at a full bank
    always_comb begin
        w_req     = bus.fifo_ready_read_i;
        w_onehot  = (w_req != '0) && ((w_req & (w_req - N_FIFO'(1))) == '0);
        w_rd_bank = '0;
        for (int k = 0; k < N_FIFO; k++) begin
            if (w_req[k]) begin
                w_rd_bank = c_bw'(k);
            end
        end
        w_pop     = w_onehot && r_full[w_rd_bank];
        w_bad     = (w_req != '0) && !w_pop;
        w_rd_idx  = r_rd_cnt[w_rd_bank];
        w_rd_last = ((w_rd_idx + c_cw'(1)) == r_level[w_rd_bank]);
    end

    // Per-bank full flag, frame length and drain position
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= '0;
            for (int k = 0; k < N_FIFO; k++) begin
                r_level[k]  <= '0;
                r_rd_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_FIFO; k++) begin
                if (w_pop && (w_rd_bank == c_bw'(k))) begin
                    if (w_rd_last) begin
                        r_full[k]   <= 1'b0;
                        r_rd_cnt[k] <= '0;
                    end else begin
                        r_rd_cnt[k] <= r_rd_cnt[k] + c_cw'(1);
                    end
                end
                if (w_close && (r_wr_sel == c_bw'(k))) begin
                    r_full[k]  <= 1'b1;
                    r_level[k] <= w_close_level;
                end
            end
        end
    end

    // Read-side flags: valid strobe, sticky protocol error, last-word marker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
`ifdef READIN_FLUSH_EN
            r_rd_last  <= 1'b0;
`endif
        end else begin
            r_rd_valid <= w_pop;
            if (w_bad) begin
                r_err <= 1'b1;
            end
`ifdef READIN_FLUSH_EN
            r_rd_last  <= w_pop & w_rd_last;
`endif
        end
    end

    // Status word assembly
    always_comb begin
        w_rd_active = 1'b0;
        for (int k = 0; k < N_FIFO; k++) begin
            if (r_rd_cnt[k] != '0) begin
                w_rd_active = 1'b1;
            end
        end
        bus.state_o                      = '0;
        bus.state_o[c_st_wr_lsb +: 2]    = r_wr_state;
        bus.state_o[c_st_rd_active]      = w_rd_active;
        bus.state_o[c_st_err]            = r_err;
    end

    assign bus.fifo_full_o = r_full;
    assign bus.rd_valid_o  = r_rd_valid;

    readin_bank_ram #(
        .DW    (DW),
        .AW    (c_bw + c_aw),
        .WORDS (N_FIFO * DEPTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_accept),
        .i_wr_addr ({r_wr_sel, r_wr_cnt[c_aw-1:0]}),
        .i_wr_data (bus.s_data_i),
        .i_rd_en   (w_pop),
        .i_rd_addr ({w_rd_bank, w_rd_idx[c_aw-1:0]}),
        .o_rd_data (bus.rd_data_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_readin_fifo_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_readin_fifo_fsm
// Description : Self-checking bench for readin_fifo_fsm with a queue-based
//               reference model and directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_readin_fifo_fsm;
    localparam int N = 5;
    localparam int W = 16;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   tb_flush = 1'b0;
    always #5 clk = ~clk;

    readin_fifo_fsm_if #(.N_FIFO(N), .DW(W)) bus ();
    readin_fifo_fsm #(.N_FIFO(N), .DW(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: banks as queues, writer as position + stalled flag
    logic [W-1:0] mq [N][$];
    bit           m_full [N];
    int           m_rdn  [N];
    int           m_wsel, m_wcnt, set_k, clr_k, hit_k, nbits;
    bit           m_stall, m_err, m_rv, m_rl, m_on, was_fill;
    logic [W-1:0] m_rd;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                mq[k].delete();
                m_full[k] = 0;
                m_rdn[k]  = 0;
            end
            m_wsel = 0; m_wcnt = 0; m_stall = 0; m_err = 0;
            m_rv = 0; m_rl = 0; m_rd = '0; m_on = 1;
        end else begin
            set_k = -1; clr_k = -1;
            if (m_stall) begin
                if (!m_full[m_wsel]) m_stall = 0;
            end else begin
                was_fill = (m_wcnt != 0);
                if (bus.s_valid_i) begin
                    mq[m_wsel].push_back(bus.s_data_i);
                    m_wcnt++;
                end
                if (m_wcnt == D || (tb_flush && was_fill)) begin
                    set_k   = m_wsel;
                    m_wsel  = (m_wsel + 1) % N;
                    m_wcnt  = 0;
                    m_stall = m_full[m_wsel];
                end
            end
            m_rv = 0; m_rl = 0;
            nbits = 0; hit_k = 0;
            for (int k = 0; k < N; k++) begin
                if (bus.fifo_ready_read_i[k]) begin
                    nbits++;
                    hit_k = k;
                end
            end
            if (nbits != 0) begin
                if (nbits == 1 && m_full[hit_k]) begin
                    m_rv = 1;
                    m_rd = mq[hit_k].pop_front();
                    if (mq[hit_k].size() == 0) begin
                        m_rl = 1; clr_k = hit_k; m_rdn[hit_k] = 0;
                    end else begin
                        m_rdn[hit_k]++;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (clr_k >= 0) m_full[clr_k] = 0;
            if (set_k >= 0) m_full[set_k] = 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [N-1:0] fv;
        bit           act;
        logic [1:0]   ws;
        if (m_on) begin
            act = 0;
            for (int k = 0; k < N; k++) begin
                fv[k] = m_full[k];
                if (m_rdn[k] != 0) act = 1;
            end
            ws = m_stall ? 2'd2 : ((m_wcnt == 0) ? 2'd0 : 2'd1);
            check("mdl_ready", 32'(bus.s_ready_o), 32'(!m_stall));
            check("mdl_full", 32'(bus.fifo_full_o), 32'(fv));
            check("mdl_rvalid", 32'(bus.rd_valid_o), 32'(m_rv));
            check("mdl_rdata", 32'(bus.rd_data_o), 32'(m_rd));
            check("mdl_state", 32'(bus.state_o), 32'({m_err, act, ws}));
`ifdef READIN_FLUSH_EN
            check("mdl_rlast", 32'(bus.rd_last_o), 32'(m_rl));
`endif
        end
    end

    task automatic step(input bit v, input logic [W-1:0] d, input logic [N-1:0] req, input bit fl);
        bus.s_valid_i         = v;
        bus.s_data_i          = d;
        bus.fifo_ready_read_i = req;
        tb_flush              = fl;
`ifdef READIN_FLUSH_EN
        bus.flush_i           = fl;
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step(0, '0, '0, 0);
        step(0, '0, '0, 0);
        reset = 1'b0;
        check("rst_ready", 32'(bus.s_ready_o), 32'h1);
        check("rst_state", 32'(bus.state_o), 32'h0);

        // Bank 0 fills after 16 words
        for (int i = 0; i < 16; i++) step(1, W'(i), '0, 0);
        check("t1_full", 32'(bus.fifo_full_o), 32'h01);
        check("t1_wstate", 32'(bus.state_o[1:0]), 32'h0);

        // Fill the remaining banks, writer stalls on full bank 0
        for (int i = 16; i < 80; i++) step(1, W'(i), '0, 0);
        step(1, W'(80), '0, 0);
        check("t2_ready", 32'(bus.s_ready_o), 32'h0);
        check("t2_wstate", 32'(bus.state_o[1:0]), 32'h2);
        check("t2_full", 32'(bus.fifo_full_o), 32'h1f);

        // Drain bank 0 in order
        for (int i = 0; i < 16; i++) begin
            step(1, W'(80), 5'b00001, 0);
            check("t3_rvalid", 32'(bus.rd_valid_o), 32'h1);
            check("t3_rdata", 32'(bus.rd_data_o), 32'(i));
        end
        check("t3_full", 32'(bus.fifo_full_o), 32'h1e);
        check("t3_ready_t1", 32'(bus.s_ready_o), 32'h0);
        step(1, W'(80), '0, 0);
        check("t3_ready_t2", 32'(bus.s_ready_o), 32'h1);

        // Refill bank 0 while draining bank 1; writer lands on bank 1 as it empties
        for (int i = 0; i < 16; i++) begin
            step(1, W'(100 + i), 5'b00010, 0);
            check("t5_rdata", 32'(bus.rd_data_o), 32'(16 + i));
        end
        check("t5_full", 32'(bus.fifo_full_o), 32'h1d);
        check("t5_stall", 32'(bus.state_o[1:0]), 32'h2);
        step(0, '0, '0, 0);
        check("t5_unstall", 32'(bus.state_o[1:0]), 32'h0);

        // Non-one-hot request
        step(0, '0, 5'b00011, 0);
        check("t4_rvalid", 32'(bus.rd_valid_o), 32'h0);
        check("t4_err", 32'(bus.state_o[3]), 32'h1);
        step(0, '0, '0, 0);
        check("t4_sticky", 32'(bus.state_o[3]), 32'h1);

        // Partial drain of bank 2, then reset
        for (int i = 0; i < 3; i++) step(0, '0, 5'b00100, 0);
        check("t5_rdata2", 32'(bus.rd_data_o), 32'd34);
        check("t5_active", 32'(bus.state_o[2]), 32'h1);
        reset = 1'b1;
        step(0, '0, '0, 0);
        reset = 1'b0;
        check("rst2_full", 32'(bus.fifo_full_o), 32'h0);
        check("rst2_rvalid", 32'(bus.rd_valid_o), 32'h0);
        check("rst2_rdata", 32'(bus.rd_data_o), 32'h0);
        check("rst2_state", 32'(bus.state_o), 32'h0);
        check("rst2_ready", 32'(bus.s_ready_o), 32'h1);

        // Request to an empty bank
        step(0, '0, 5'b00100, 0);
        check("t4_empty_rv", 32'(bus.rd_valid_o), 32'h0);
        check("t4_empty_err", 32'(bus.state_o[3]), 32'h1);
        reset = 1'b1;
        step(0, '0, '0, 0);
        reset = 1'b0;

`ifdef READIN_FLUSH_EN
        // Five words then flush
        for (int i = 0; i < 5; i++) step(1, W'(16'h00A0 + i), '0, 0);
        step(0, '0, '0, 1);
        check("t6_full", 32'(bus.fifo_full_o), 32'h01);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 5'b00001, 0);
            check("t6_rdata", 32'(bus.rd_data_o), 32'(16'h00A0 + i));
            check("t6_rlast", 32'(bus.rd_last_o), 32'(i == 4));
        end
        check("t6_drained", 32'(bus.fifo_full_o), 32'h0);
        // Flush together with an accepted word: that word is part of the frame
        for (int i = 0; i < 3; i++) step(1, W'(16'h00B0 + i), '0, 0);
        step(1, W'(16'h00B3), '0, 1);
        for (int i = 0; i < 4; i++) step(0, '0, 5'b00010, 0);
        check("t6_last4", 32'(bus.rd_data_o), 32'h00B3);
        check("t6_rlast4", 32'(bus.rd_last_o), 32'h1);
`else
        for (int i = 0; i < 16; i++) step(1, W'(16'h0200 + i), '0, 0);
        for (int i = 0; i < 16; i++) step(0, '0, 5'b00001, 0);
        check("t6_last", 32'(bus.rd_data_o), 32'h020F);
        check("t6_drained", 32'(bus.fifo_full_o), 32'h0);
`endif
        step(0, '0, '0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
